// File: rtl/cipher_round_ctrl.sv
// Multi-round sequencer around an external single-round cipher datapath: iterates one
// plaintext word NUM_ROUNDS times with per-round keys, whitens with a final key.
module cipher_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 2,
    parameter int unsigned KEY_IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_message,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_message,
    output logic                 busy,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [15:0]          round_key,
    output logic [15:0]          rnd_in,
    output logic [15:0]          rnd_key,
    input  logic [15:0]          rnd_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [KEY_IDX_W-1:0] LAST_RND  = KEY_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] FINAL_IDX = KEY_IDX_W'(NUM_ROUNDS);

    logic [1:0]           fsm_q, fsm_d;
    logic [KEY_IDX_W-1:0] round_cnt_q, round_cnt_d;
    logic [15:0]          state_reg_q, state_reg_d;
    logic [15:0]          out_message_q, out_message_d;
    logic                 out_valid_q, out_valid_d;

    always_comb begin
        fsm_d         = fsm_q;
        round_cnt_d   = round_cnt_q;
        state_reg_d   = state_reg_q;
        out_message_d = out_message_q;
        out_valid_d   = out_valid_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_reg_d = in_message;
                    round_cnt_d = '0;
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
                state_reg_d = rnd_out;
                round_cnt_d = round_cnt_q + KEY_IDX_W'(1);
                if (round_cnt_q == LAST_RND) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                // Final whitening uses key NUM_ROUNDS, selected by key_idx in this state.
                out_message_d = state_reg_q ^ round_key;
                out_valid_d   = 1'b1;
                fsm_d         = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= IDLE;
            round_cnt_q   <= '0;
            state_reg_q   <= '0;
            out_message_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            round_cnt_q   <= round_cnt_d;
            state_reg_q   <= state_reg_d;
            out_message_q <= out_message_d;
            out_valid_q   <= out_valid_d;
        end
    end

    always_comb begin
        key_idx = '0;
        unique case (fsm_q)
            ROUND:   key_idx = round_cnt_q;
            FINAL:   key_idx = FINAL_IDX;
            default: key_idx = '0;
        endcase
    end

    assign in_ready    = (fsm_q == IDLE) && !rst;
    assign busy        = (fsm_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_message = out_message_q;
    assign rnd_in      = state_reg_q;
    assign rnd_key     = round_key;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Bench for cipher_round_ctrl: two instances (NUM_ROUNDS=2 and 1) sharing one key store,
// selectable stub or full round datapath, checked against a round-loop reference model.
module tb_cipher_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, sel, use_stub;
    logic [15:0] in_message;
    logic [15:0] keys [16];

    logic        a_in_ready, a_out_valid, a_busy;
    logic [15:0] a_out_message, a_rnd_in, a_rnd_key, a_rnd_out, a_round_key;
    logic [3:0]  a_key_idx;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [15:0] b_out_message, b_rnd_in, b_rnd_key, b_rnd_out, b_round_key;
    logic [3:0]  b_key_idx;

    logic        cur_in_ready, cur_out_valid, cur_busy;
    logic [15:0] cur_out_message;
    logic [3:0]  cur_key_idx;

    int pass_cnt = 0;
    int total    = 0;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // Key add, nibble s-boxes, shiftrow on a 2x2 nibble matrix, byte-column mix.
    function automatic logic [15:0] round_fn(input logic [15:0] d, input logic [15:0] k);
        logic [15:0] x, s, y;
        x = d ^ k;
        for (int i = 0; i < 4; i++) s[4*i +: 4] = sbox4(x[4*i +: 4]);
        y = {s[15:12], s[3:0], s[7:4], s[11:8]};
        return {y[15:8] ^ y[7:0], y[15:8]};
    endfunction

    function automatic logic [15:0] model(input logic [15:0] m, input int nr, input logic stub);
        logic [15:0] c;
        c = m;
        for (int r = 0; r < nr; r++) c = stub ? (c ^ keys[r]) : round_fn(c, keys[r]);
        return c ^ keys[nr];
    endfunction

    function automatic logic [15:0] exp_kseq(input int nr);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i <= nr; i++) v |= 16'(i) << (4 * i);
        return v;
    endfunction

    assign a_round_key = keys[a_key_idx];
    assign b_round_key = keys[b_key_idx];
    assign a_rnd_out   = use_stub ? (a_rnd_in ^ a_rnd_key) : round_fn(a_rnd_in, a_rnd_key);
    assign b_rnd_out   = use_stub ? (b_rnd_in ^ b_rnd_key) : round_fn(b_rnd_in, b_rnd_key);

    cipher_round_ctrl #(.NUM_ROUNDS(2), .KEY_IDX_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_message(in_message),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_message(a_out_message),
        .busy(a_busy), .key_idx(a_key_idx), .round_key(a_round_key),
        .rnd_in(a_rnd_in), .rnd_key(a_rnd_key), .rnd_out(a_rnd_out)
    );

    cipher_round_ctrl #(.NUM_ROUNDS(1), .KEY_IDX_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_message(in_message),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_message(b_out_message),
        .busy(b_busy), .key_idx(b_key_idx), .round_key(b_round_key),
        .rnd_in(b_rnd_in), .rnd_key(b_rnd_key), .rnd_out(b_rnd_out)
    );

    assign cur_in_ready    = sel ? b_in_ready    : a_in_ready;
    assign cur_out_valid   = sel ? b_out_valid   : a_out_valid;
    assign cur_busy        = sel ? b_busy        : a_busy;
    assign cur_out_message = sel ? b_out_message : a_out_message;
    assign cur_key_idx     = sel ? b_key_idx     : a_key_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offer msg, wait for accept, then count edges until out_valid while logging key_idx.
    task automatic run_word(input logic [15:0] msg, output logic [15:0] got, output int lat,
                            output logic [15:0] kseq);
        int w = 0;
        in_message = msg;
        in_valid   = 1'b1;
        while (!cur_in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_idle", cur_in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 0;
        kseq = '0;
        while (!cur_out_valid && lat < 40) begin
            if (lat < 4) kseq |= 16'(cur_key_idx) << (4 * lat);
            @(posedge clk); #1; lat++;
        end
        got = cur_out_message;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", cur_out_valid, 0);
        check("in_ready_after_hs", cur_in_ready, 1);
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] msg, k0, k1, k2, exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [15:0] got, kseq, msg, expv, held;
        int          lat, nr, cyc, nacc, nout, ov_cnt;
        int          acc [2];
        logic [15:0] outs [2];
        logic        acc_now, out_now;
        logic [15:0] om;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; use_stub = 1'b1;
        in_message = '0;
        for (int i = 0; i < 16; i++) keys[i] = '0;

        vecs[0] = '{1'b0, 16'h0000, 16'h1111, 16'h2222, 16'h4444, 16'h7777, 3};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0002, 16'h0004, 16'hFFF8, 3};
        vecs[2] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'h0000, 16'hFFFF, 16'h0000, 3};
        vecs[3] = '{1'b1, 16'hA5A5, 16'h00FF, 16'h0F00, 16'h0000, 16'hAA5A, 2};
        vecs[4] = '{1'b1, 16'h1234, 16'h1000, 16'h0200, 16'h0000, 16'h0034, 2};
        vecs[5] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 3};

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_out_valid", cur_out_valid, 0);
            check("rst_busy", cur_busy, 0);
            check("rst_in_ready", cur_in_ready, 0);
            check("rst_out_message", cur_out_message, 0);
        end
        sel = 1'b0;
        rst = 1'b0;
        #1;
        check("in_ready_post_rst", cur_in_ready, 1);

        // Directed vectors with the XOR stub datapath.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            use_stub = 1'b1;
            keys[0] = vecs[i].k0; keys[1] = vecs[i].k1; keys[2] = vecs[i].k2;
            nr = sel ? 1 : 2;
            run_word(vecs[i].msg, got, lat, kseq);
            check("vec_out_message", got, vecs[i].exp);
            check("vec_latency", lat, vecs[i].lat);
            check("vec_key_idx_seq", kseq, exp_kseq(nr));
            release_out();
        end

        // Output backpressure.
        sel = 1'b0; use_stub = 1'b1;
        keys[0] = 16'h0001; keys[1] = 16'h0010; keys[2] = 16'h0100;
        run_word(16'h0000, got, lat, kseq);
        check("bp_out_message", got, 16'h0111);
        held = got;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", cur_out_valid, 1);
            check("bp_out_stable", cur_out_message, held);
            check("bp_in_ready", cur_in_ready, 0);
            check("bp_busy", cur_busy, 1);
        end
        release_out();

        // Back-to-back: in_valid held, sink always ready.
        in_message = 16'h1000; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; nacc = 0; nout = 0; acc[0] = 0; acc[1] = 0; outs[0] = '0; outs[1] = '0;
        while (cyc < 40 && nout < 2) begin
            acc_now = in_valid && cur_in_ready;
            out_now = cur_out_valid && out_ready;
            om      = cur_out_message;
            @(posedge clk); #1; cyc++;
            if (out_now) begin
                if (nout < 2) outs[nout] = om;
                nout++;
            end
            if (acc_now) begin
                if (nacc < 2) acc[nacc] = cyc;
                nacc++;
                if (nacc == 1) in_message = 16'h2000;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", nacc, 2);
        check("b2b_outputs", nout, 2);
        check("b2b_out0", outs[0], 16'h1111);
        check("b2b_out1", outs[1], 16'h2111);
        check("b2b_spacing", acc[1] - acc[0], 5);

        // Reset while in ROUND with round_cnt=1.
        in_message = 16'h0ABC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_key_idx", cur_key_idx, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", cur_out_valid, 0);
        check("mid_rst_out_message", cur_out_message, 0);
        check("mid_rst_busy", cur_busy, 0);
        check("mid_rst_in_ready", cur_in_ready, 0);
        rst = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cur_out_valid) ov_cnt++;
        end
        check("mid_rst_no_output", ov_cnt, 0);
        run_word(16'h0ABC, got, lat, kseq);
        check("post_rst_out_message", got, 16'h0BAD);
        check("post_rst_latency", lat, 3);
        release_out();

        // Randomised words through the full round datapath on both instances.
        use_stub = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            nr  = sel ? 1 : 2;
            for (int n = 0; n < (sel ? 200 : 1000); n++) begin
                for (int k = 0; k <= nr; k++) keys[k] = 16'($urandom);
                msg  = 16'($urandom);
                expv = model(msg, nr, 1'b0);
                run_word(msg, got, lat, kseq);
                check("rand_out_message", got, expv);
                check("rand_latency", lat, nr + 1);
                release_out();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/cipher_round_ctrl.md
Name: cipher_round_ctrl

Overview:
Multi-round sequencer for the 16-bit single-round cipher datapath (key add, 4x s_box, shiftrow, mixcols).
- Accepts one plaintext word and iterates it through the external round datapath NUM_ROUNDS times, fetching one round key per pass from an external key store.
- Applies a final key whitening XOR.
- Returns the ciphertext over a valid/ready handshake.
- Sits between the message source/sink and the round datapath instance.

Parameters:
- NUM_ROUNDS, 2: passes through the round datapath; legal range 1..15.
- KEY_IDX_W, 4: width of key_idx; must satisfy 2^KEY_IDX_W > NUM_ROUNDS.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext valid.
- in_ready  output  1  controller can accept plaintext.
- in_message  input  16  plaintext word.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- out_message  output  16  ciphertext, registered.
- busy  output  1  high in any state other than IDLE.
- key_idx  output  KEY_IDX_W  round-key index to the key store.
- round_key  input  16  key for key_idx; combinational from the key store, valid in the same cycle.
- rnd_in  output  16  data to the round datapath (in_message port).
- rnd_key  output  16  key to the round datapath (in_key port).
- rnd_out  input  16  round datapath result (out_message port); combinational.

Behaviour:
- Reset (rst high at an edge) applies regardless of the current state. A transaction in flight is discarded and nothing is emitted.
  - State goes to IDLE; round_cnt, state_reg and out_message all become 0.
  - out_valid = 0 and busy = 0.
  - in_ready = 0 while rst is high.
- State machine: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1, key_idx = 0.
  - On in_valid && in_ready: state_reg <= in_message, round_cnt <= 0, go to ROUND.
  - in_valid while not in IDLE is ignored; the source must hold its data.
- ROUND (one cycle per round):
  - key_idx = round_cnt, rnd_in = state_reg, rnd_key = round_key.
  - At the edge: state_reg <= rnd_out and round_cnt <= round_cnt + 1.
  - If round_cnt == NUM_ROUNDS-1, go to FINAL instead of staying in ROUND.
- FINAL:
  - key_idx = NUM_ROUNDS.
  - At the edge: out_message <= state_reg ^ round_key, out_valid <= 1, go to DONE.
- DONE:
  - out_valid = 1; out_message is held stable until the handshake.
  - On out_ready: out_valid <= 0, go to IDLE.
  - out_ready while out_valid = 0 has no effect.
- rnd_in = state_reg and rnd_key = round_key in all states. The datapath output is consumed only in ROUND.
- Latency: if input is accepted at edge k, out_valid is high from edge k+NUM_ROUNDS+1 onward.
- Throughput: one bubble cycle in IDLE between out handshake and the next accept. Max rate is one word per NUM_ROUNDS+3 cycles.
- round_cnt is KEY_IDX_W bits wide and never exceeds NUM_ROUNDS; no wrap.
- No arithmetic beyond 16-bit XOR and the counter increment.

Test Plan:
- Stub datapath: rnd_out = rnd_in ^ rnd_key.
  - Config: NUM_ROUNDS=2, keys k0=0x1111, k1=0x2222, k2=0x4444, in_message=0x0000.
  - Required: out_message=0x7777; out_valid rises 3 edges after accept; key_idx sequence 0,1,2.
- Real round datapath, NUM_ROUNDS=2, random plaintext/keys (1000 words) vs bench golden model.
  - Each out_message matches the model; out_valid latency always 3 edges.
- Output backpressure: out_ready held low 10 cycles in DONE.
  - out_valid stays 1, out_message stable, in_ready 0, busy 1.
  - Then out_ready=1 for one cycle: out_valid drops next edge, in_ready=1.
- Back-to-back: in_valid held high with two words, out_ready tied 1, stub datapath.
  - Two outputs, second accepted exactly NUM_ROUNDS+3 cycles after the first.
- Reset mid-operation: assert rst during ROUND (round_cnt=1).
  - Next edge: IDLE, out_valid=0, out_message=0x0000, busy=0; no output for the aborted word.
  - The next word processes correctly.
- NUM_ROUNDS=1, stub datapath, in_message=0xA5A5, k0=0x00FF, k1=0x0F00.
  - out_message=0xAA5A, latency 2 edges; key_idx sequence 0,1.
